// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks an h/v pixel counter pair on each pix_en step and produces
// syncs, video_on, blanked RGB and line/frame start pulses, all registered one step late.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned RGB_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb_out,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);

    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic h_wrap, v_wrap, active, in_hsync, in_vsync;

    // Decode is taken from the pre-increment counters so outputs trail x/y by one step.
    always_comb begin
        h_wrap   = (h_cnt_q == HLast);
        v_wrap   = (v_cnt_q == VLast);
        active   = (h_cnt_q < HActive) && (v_cnt_q < VActive);
        in_hsync = (h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd);
        in_vsync = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        rgb_out_d     = rgb_out_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pix_en) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
            end
            hsync_d       = in_hsync ? SYNC_POL : ~SYNC_POL;
            vsync_d       = in_vsync ? SYNC_POL : ~SYNC_POL;
            video_on_d    = active;
            rgb_out_d     = active ? rgb_in : '0;
            line_start_d  = (h_cnt_q == 10'd0);
            frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            rgb_out_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            rgb_out_q     <= rgb_out_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb_out     = rgb_out_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench: a default 640x480 instance and a tiny active-high-sync instance
// share stimulus; a linear pixel-index model predicts every clock's outputs.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        von;
        logic [11:0] rgb;
        logic        ls;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [11:0] rgb_in = '0;

    logic [9:0]  x0, y0, x1, y1;
    logic        hs0, vs0, von0, ls0, fs0, hs1, vs1, von1, ls1, fs1;
    logic [11:0] rgb0, rgb1;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in),
        .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .video_on(von0), .rgb_out(rgb0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .RGB_W(12)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in),
        .x(x1), .y(y1), .hsync(hs1), .vsync(vs1), .video_on(von1), .rgb_out(rgb1),
        .line_start(ls1), .frame_start(fs1)
    );

    int ha[2] = '{640, 8};
    int hf[2] = '{16, 2};
    int hw[2] = '{96, 3};
    int hb[2] = '{48, 2};
    int va[2] = '{480, 6};
    int vf[2] = '{10, 1};
    int vw[2] = '{2, 2};
    int vb[2] = '{33, 1};
    bit pol[2] = '{1'b0, 1'b1};

    int   pos[2];
    exp_t last[2];
    exp_t q0[$];
    exp_t q1[$];

    int vectors = 0;
    int miscompares = 0;
    int fs_seen[2] = '{0, 0};
    bit done = 1'b0;

    // Position is a linear index into the frame; x/y fall out of div/mod.
    task automatic model(input int i, input bit r, input bit pe, input logic [11:0] c);
        exp_t e;
        int   ht, vt, xx, yy;
        bit   act;
        ht = ha[i] + hf[i] + hw[i] + hb[i];
        vt = va[i] + vf[i] + vw[i] + vb[i];
        e  = last[i];
        if (!r) begin
            pos[i] = 0;
            e.hs = ~pol[i]; e.vs = ~pol[i]; e.von = 1'b0; e.rgb = '0; e.ls = 1'b0; e.fs = 1'b0;
        end else if (pe) begin
            xx  = pos[i] % ht;
            yy  = pos[i] / ht;
            act = (xx < ha[i]) && (yy < va[i]);
            e.hs  = (xx >= ha[i] + hf[i] && xx < ha[i] + hf[i] + hw[i]) ? pol[i] : ~pol[i];
            e.vs  = (yy >= va[i] + vf[i] && yy < va[i] + vf[i] + vw[i]) ? pol[i] : ~pol[i];
            e.von = act;
            e.rgb = act ? c : 12'h000;
            e.ls  = (xx == 0);
            e.fs  = (pos[i] == 0);
            pos[i] = (pos[i] + 1) % (ht * vt);
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        e.x = 10'(pos[i] % ht);
        e.y = 10'(pos[i] / ht);
        last[i] = e;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input bit r, input bit pe);
        rst    = r;
        pix_en = pe;
        rgb_in = 12'($urandom_range(0, 4095));
        model(0, r, pe, rgb_in);
        model(1, r, pe, rgb_in);
    endtask

    task automatic check(input string name, input exp_t got, input exp_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b von=%b rgb=%h ls=%b fs=%b | required x=%0d y=%0d hs=%b vs=%b von=%b rgb=%h ls=%b fs=%b",
                     name, $time, got.x, got.y, got.hs, got.vs, got.von, got.rgb, got.ls, got.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.rgb, exp.ls, exp.fs);
        end
    endtask

    // Monitor: the DUT presents a result every clock; pop and compare away from the edge.
    initial begin : monitor
        exp_t e, g;
        while (!done) begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = '{x0, y0, hs0, vs0, von0, rgb0, ls0, fs0};
                check("vga640", g, e);
                if (fs0 === 1'b1) fs_seen[0]++;
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = '{x1, y1, hs1, vs1, von1, rgb1, ls1, fs1};
                check("vga_small", g, e);
                if (fs1 === 1'b1) fs_seen[1]++;
            end
        end
    end

    initial begin : driver
        int exp_fs;
        pos[0] = 0; pos[1] = 0;
        last[0] = '0; last[1] = '0;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b0, 1'b1);
        end
        // Continuous stepping over several lines, with a mid-line reset.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk); drive(!(i == 1300 || i == 1301), 1'b1);
        end
        // One step in four.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); drive(1'b1, (i % 4) == 0);
        end
        // Random enables with rare resets.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); drive($urandom_range(0, 4999) != 0, $urandom_range(0, 2) != 0);
        end
        // Clean small-frame run to count frame_start pulses.
        @(negedge clk); drive(1'b0, 1'b0);
        fs_seen[1] = 0;
        for (int i = 0; i < 150 * 6; i++) begin
            @(negedge clk); drive(1'b1, 1'b1);
        end
        @(negedge clk); drive(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        exp_fs = 6;
        vectors++;
        if (fs_seen[1] != exp_fs) begin
            miscompares++;
            $display("FAIL small_frame_count got %0d required %0d", fs_seen[1], exp_fs);
        end
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
